// File: rtl/seq_value_formatter.sv
// Signed binary to packed BCD formatter for the on-screen number display.
// Runs a serial double-dabble conversion, then holds the result until a frame_start pulse publishes it.
module seq_value_formatter #(
    parameter int VALUE_WIDTH = 16,
    parameter int DIGITS      = 5,
    parameter int INT_DIGITS  = (VALUE_WIDTH*3+9)/10 + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VALUE_WIDTH-1:0] in_value,
    input  logic                   frame_start,
    output logic [DIGITS*4-1:0]    bcd_out,
    output logic                   neg_out,
    output logic                   ovf_out,
    output logic                   busy
);

    localparam int SW = INT_DIGITS*4;
    localparam int CW = $clog2(VALUE_WIDTH+1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [VALUE_WIDTH-1:0] mag_q, mag_d;
    logic [SW-1:0]          scratch_q, scratch_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DIGITS*4-1:0]    shadow_bcd_q, shadow_bcd_d;
    logic                   shadow_neg_q, shadow_neg_d;
    logic                   shadow_ovf_q, shadow_ovf_d;
    logic [DIGITS*4-1:0]    bcd_q, bcd_d;
    logic                   neg_q, neg_d;
    logic                   ovf_q, ovf_d;

    logic [SW-1:0]          adjusted;
    logic [SW-1:0]          shifted;
    logic                   ovf_calc;
    logic [DIGITS*4-1:0]    sat_bcd;

    // One double-dabble step: add 3 to nibbles >= 5, then shift the next magnitude bit in.
    always_comb begin
        adjusted = '0;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (scratch_q[i*4 +: 4] >= 4'd5)
                adjusted[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
            else
                adjusted[i*4 +: 4] = scratch_q[i*4 +: 4];
        end
        shifted = {adjusted[SW-2:0], mag_q[VALUE_WIDTH-1]};

        ovf_calc = 1'b0;
        for (int i = DIGITS; i < INT_DIGITS; i++)
            ovf_calc = ovf_calc | (|shifted[i*4 +: 4]);

        sat_bcd = '0;
        for (int i = 0; i < DIGITS; i++)
            sat_bcd[i*4 +: 4] = 4'd9;
    end

    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        mag_d        = mag_q;
        scratch_d    = scratch_q;
        cnt_d        = cnt_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_neg_d = shadow_neg_q;
        shadow_ovf_d = shadow_ovf_q;
        bcd_d        = bcd_q;
        neg_d        = neg_q;
        ovf_d        = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // A zero input never carries a sign, so -0 cannot reach the display.
                    sign_d    = in_value[VALUE_WIDTH-1] & (|in_value);
                    mag_d     = in_value[VALUE_WIDTH-1] ? -in_value : in_value;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = shifted;
                mag_d     = mag_q << 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(VALUE_WIDTH-1)) begin
                    shadow_ovf_d = ovf_calc;
                    shadow_bcd_d = ovf_calc ? sat_bcd : shifted[DIGITS*4-1:0];
                    shadow_neg_d = sign_q;
                    state_d      = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    bcd_d   = shadow_bcd_q;
                    neg_d   = shadow_neg_q;
                    ovf_d   = shadow_ovf_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sign_q       <= 1'b0;
            mag_q        <= '0;
            scratch_q    <= '0;
            cnt_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_neg_q <= 1'b0;
            shadow_ovf_q <= 1'b0;
            bcd_q        <= '0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sign_q       <= sign_d;
            mag_q        <= mag_d;
            scratch_q    <= scratch_d;
            cnt_q        <= cnt_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_neg_q <= shadow_neg_d;
            shadow_ovf_q <= shadow_ovf_d;
            bcd_q        <= bcd_d;
            neg_q        <= neg_d;
            ovf_q        <= ovf_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign bcd_out  = bcd_q;
    assign neg_out  = neg_q;
    assign ovf_out  = ovf_q;

endmodule

// File: tb/tb_seq_value_formatter.sv
// Directed plus random bench for seq_value_formatter, run with DIGITS=5 and DIGITS=4 side by side.
module tb_seq_value_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_value;
    logic        frame_start;

    logic        in_ready_a, neg_a, ovf_a, busy_a;
    logic [19:0] bcd_a;
    logic        in_ready_b, neg_b, ovf_b, busy_b;
    logic [15:0] bcd_b;

    int errors = 0;
    int checks = 0;

    // Published values the display should currently show, and the value awaiting publish.
    logic [19:0] exp_bcd5, pend_bcd5;
    logic [15:0] exp_bcd4, pend_bcd4;
    logic        exp_neg, pend_neg;
    logic        exp_ovf5, pend_ovf5;
    logic        exp_ovf4, pend_ovf4;

    always #5 clk = ~clk;

    seq_value_formatter #(.VALUE_WIDTH(16), .DIGITS(5)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_value(in_value), .frame_start(frame_start), .bcd_out(bcd_a),
        .neg_out(neg_a), .ovf_out(ovf_a), .busy(busy_a)
    );

    seq_value_formatter #(.VALUE_WIDTH(16), .DIGITS(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_value(in_value), .frame_start(frame_start), .bcd_out(bcd_b),
        .neg_out(neg_b), .ovf_out(ovf_b), .busy(busy_b)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Decimal reference: magnitude by plain arithmetic, digits by repeated division.
    task automatic model(input logic [15:0] v, output logic [19:0] b5, output logic o5,
                         output logic n, output logic [15:0] b4, output logic o4);
        int sv;
        int mag;
        int t;
        sv  = int'($signed(v));
        mag = (sv < 0) ? -sv : sv;
        n   = (sv < 0);
        o5  = (mag > 99999);
        o4  = (mag > 9999);
        t   = mag;
        b5  = '0;
        for (int i = 0; i < 5; i++) begin
            b5[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        b4 = o4 ? 16'h9999 : b5[15:0];
        if (o5) b5 = 20'h99999;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_bcd5"}, 32'(bcd_a), 32'(exp_bcd5));
        chk({tag, "_neg5"}, 32'(neg_a), 32'(exp_neg));
        chk({tag, "_ovf5"}, 32'(ovf_a), 32'(exp_ovf5));
        chk({tag, "_bcd4"}, 32'(bcd_b), 32'(exp_bcd4));
        chk({tag, "_neg4"}, 32'(neg_b), 32'(exp_neg));
        chk({tag, "_ovf4"}, 32'(ovf_b), 32'(exp_ovf4));
    endtask

    task automatic check_hs(input string tag, input logic rdy, input logic bsy);
        chk({tag, "_ready5"}, 32'(in_ready_a), 32'(rdy));
        chk({tag, "_busy5"},  32'(busy_a),     32'(bsy));
        chk({tag, "_ready4"}, 32'(in_ready_b), 32'(rdy));
        chk({tag, "_busy4"},  32'(busy_b),     32'(bsy));
    endtask

    // Completes one handshake; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] v);
        int n;
        n        = 0;
        in_value = v;
        in_valid = 1'b1;
        while (!in_ready_a && n < 100) begin
            step(1);
            n++;
        end
        chk("accept_wait", 32'(n < 100), 32'd1);
        step(1);
        in_valid = 1'b0;
        in_value = 16'($urandom);
        model(v, pend_bcd5, pend_ovf5, pend_neg, pend_bcd4, pend_ovf4);
        check_hs("accepted", 1'b0, 1'b1);
    endtask

    // Waits n cycles while the conversion/pending phase must keep outputs frozen.
    task automatic hold_wait(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1);
            check_hs(tag, 1'b0, 1'b1);
            check_outs(tag);
        end
    endtask

    task automatic publish(input string tag);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        exp_bcd5 = pend_bcd5;
        exp_bcd4 = pend_bcd4;
        exp_neg  = pend_neg;
        exp_ovf5 = pend_ovf5;
        exp_ovf4 = pend_ovf4;
        check_outs(tag);
        check_hs({tag, "_idle"}, 1'b1, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_value    = '0;
        frame_start = 1'b0;
        exp_bcd5 = '0; exp_bcd4 = '0; exp_neg = 1'b0; exp_ovf5 = 1'b0; exp_ovf4 = 1'b0;
        step(3);
        check_outs("reset");
        rst = 1'b0;
        step(1);
        check_hs("after_reset", 1'b1, 1'b0);
        check_outs("after_reset");

        // 12345: fits five digits, saturates four.
        send(16'd12345);
        hold_wait(30, "hold_12345");
        publish("pub_12345");

        send(16'hFC75);   // -907
        hold_wait(17, "hold_m907");
        publish("pub_m907");

        send(16'h8000);   // -32768
        hold_wait(17, "hold_m32768");
        publish("pub_m32768");

        // 0 then -1, with a third request offered while pending.
        send(16'd0);
        hold_wait(17, "hold_zero");
        publish("pub_zero");
        send(16'hFFFF);
        hold_wait(17, "hold_m1");
        in_value = 16'd555;
        in_valid = 1'b1;
        hold_wait(3, "pending_reject");
        in_valid = 1'b0;
        publish("pub_m1");
        step(2);
        check_hs("not_accepted", 1'b1, 1'b0);

        send(16'd9999);
        hold_wait(17, "hold_9999");
        publish("pub_9999");

        // frame_start during CONVERT and on the final conversion edge must not publish.
        send(16'd4321);
        step(4);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check_outs("fs_convert");
        step(10);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check_outs("fs_last_step");
        check_hs("fs_last_step", 1'b0, 1'b1);
        hold_wait(2, "hold_4321");
        publish("pub_4321");

        // Asynchronous reset in the middle of a conversion.
        send(16'd777);
        step(6);
        #2;
        rst = 1'b1;
        #1;
        exp_bcd5 = '0; exp_bcd4 = '0; exp_neg = 1'b0; exp_ovf5 = 1'b0; exp_ovf4 = 1'b0;
        check_outs("async_reset");
        step(1);
        rst = 1'b0;
        step(1);
        check_hs("post_reset", 1'b1, 1'b0);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check_outs("post_reset_fs");
        check_hs("post_reset_fs", 1'b1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            send(16'($urandom));
            hold_wait($urandom_range(16, 30), "rand_hold");
            publish("rand_pub");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_value_formatter.md
Name: seq_value_formatter

Overview:
- Upstream feeder for the on-screen BCD number display stage.
- Accepts a signed binary value and converts its magnitude to packed BCD with an iterative double-dabble engine, one shift per clock.
- Holds the result in a shadow register and publishes it to the display only on a frame-start pulse, so digits never change mid-frame (no tearing).
- Provides a valid/ready handshake toward the game/score logic.

Parameters:
- VALUE_WIDTH, 16: width of the signed two's-complement input value.
- DIGITS, 5: number of BCD digits published on bcd_out.
- INT_DIGITS, (VALUE_WIDTH*3+9)/10 + 1: internal BCD scratch digits. Must be >= DIGITS and large enough for 2^(VALUE_WIDTH-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_value is presented this cycle.
- in_ready  out  1  block can accept a value this cycle.
- in_value  in  VALUE_WIDTH  signed value to format.
- frame_start  in  1  single-cycle pulse at start of vertical blanking.
- bcd_out  out  DIGITS*4  published BCD magnitude; digit 0 in bits [3:0].
- neg_out  out  1  published sign; 1 = display minus glyph.
- ovf_out  out  1  published magnitude exceeded 10^DIGITS-1.
- busy  out  1  conversion or publish pending.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; bcd_out=0, neg_out=0, ovf_out=0; shadow registers cleared.
  - An in-flight conversion is discarded.
  - in_ready=1 and busy=0 from the first clock after reset deasserts.
- States: IDLE, CONVERT, PENDING.
  - in_ready = (state==IDLE).
  - busy = (state!=IDLE).
- IDLE: on in_valid & in_ready:
  - Capture sign = in_value[MSB].
  - Capture magnitude = |in_value| as an unsigned VALUE_WIDTH-bit value. The most negative value gives 2^(VALUE_WIDTH-1) with no overflow.
  - Clear BCD scratch, iteration counter=0, go to CONVERT.
- CONVERT: each cycle performs one double-dabble step:
  - Every scratch nibble >=5 gets +3.
  - Then {scratch, magnitude} shifts left by 1.
  - Counter increments.
  - After exactly VALUE_WIDTH steps, load the shadow registers and go to PENDING.
- Shadow load rules:
  - shadow_ovf = 1 if any scratch digit at index >= DIGITS is nonzero.
  - If shadow_ovf: shadow_bcd = all digits 9 (saturate); otherwise shadow_bcd = low DIGITS digits.
  - shadow_neg = sign & (magnitude != 0), so -0 is never displayed.
- PENDING: on a frame_start sampled high:
  - bcd_out/neg_out/ovf_out <= shadow (visible the next cycle).
  - Go to IDLE.
  - Outputs are otherwise held.
- frame_start in IDLE or CONVERT is ignored. A frame_start in the same cycle as CONVERT->PENDING does not publish; the next one does.
- in_valid while in_ready=0 is ignored: the value is dropped and there is no queueing. The producer must hold in_valid until a handshake completes.
- Latency:
  - Accept at cycle 0; PENDING entered at cycle VALUE_WIDTH.
  - Minimum accept-to-output = VALUE_WIDTH+2 cycles.
  - Worst case adds one frame period.
- At most one output update per frame_start pulse. Outputs never change except at reset or a publish.

Test Plan:
- Reset, then in_value=12345 accepted, frame_start pulsed 30 cycles later -> bcd_out=0x12345, neg_out=0, ovf_out=0 on the cycle after the pulse. busy high from accept until that cycle.
- in_value=-907 -> bcd_out=0x00907, neg_out=1; in_value=-32768 -> bcd_out=0x32768, neg_out=1, ovf_out=0.
- in_value=0 and in_value=-1 back-to-back across two frames -> first publish 0x00000/neg 0, second 0x00001/neg 1. in_ready low throughout each CONVERT/PENDING; a third in_valid asserted during PENDING is not accepted.
- DIGITS=4: in_value=12345 -> bcd_out=0x9999, ovf_out=1; in_value=9999 -> 0x9999, ovf_out=0.
- frame_start pulsed during CONVERT and exactly on the CONVERT->PENDING cycle -> outputs unchanged; the next frame_start publishes.
- rst asserted mid-CONVERT (cycle 7) -> bcd_out/neg_out/ovf_out=0 immediately (asynchronous). After release, in_ready=1 and a later frame_start publishes nothing.
